// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order commit buffer sitting between the register file's issue
//   stage and the common data bus. Entries are allocated in program order,
//   tagged by PC, filled from CDB broadcasts, and retired strictly in order.
//   A retiring mispredicted control transfer raises the exception pulse and
//   flushes every entry in the same edge.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   is_ready_from_rf         issue request, with pc_from_rf / rd_from_rf
//   is_valid_from_cdb        result broadcast, with pc/data/is_jump/target
//   is_ready_to_rf           a free entry exists and no flush is in progress
//   is_commit_to_rf          one-cycle pulse retiring a normal entry
//   is_exception_to_rf       one-cycle pulse retiring a mispredict (flush)
//   rd_to_rf/data_to_rf/pc_to_rf  registered retiring-entry fields
//   target_to_fetch          redirect PC, meaningful with is_exception_to_rf
//   is_full_to_rf/is_empty_to_rf  occupancy flags
module reorder_buffer #(
  parameter int unsigned Depth     = 16,
  parameter int unsigned DepthLog2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_ready_from_rf,
  input  logic [31:0] pc_from_rf,
  input  logic [4:0]  rd_from_rf,
  input  logic        is_valid_from_cdb,
  input  logic [31:0] pc_from_cdb,
  input  logic [31:0] data_from_cdb,
  input  logic        is_jump_from_cdb,
  input  logic [31:0] target_from_cdb,
  output logic        is_ready_to_rf,
  output logic        is_commit_to_rf,
  output logic        is_exception_to_rf,
  output logic [4:0]  rd_to_rf,
  output logic [31:0] data_to_rf,
  output logic [31:0] pc_to_rf,
  output logic [31:0] target_to_fetch,
  output logic        is_full_to_rf,
  output logic        is_empty_to_rf
);

  localparam logic [DepthLog2:0] FullCount = (DepthLog2+1)'(Depth);

  logic [Depth-1:0]     valid, done, jump;
  logic [31:0]          pc_q     [Depth];
  logic [4:0]           rd_q     [Depth];
  logic [31:0]          data_q   [Depth];
  logic [31:0]          target_q [Depth];
  logic [DepthLog2-1:0] head, tail;
  logic [DepthLog2:0]   count;

  logic alloc, commit_ok, commit_jump, cdb_en;

  // The exception pulse doubles as the flush flag: while it is high the
  // buffer is already empty and all issue/CDB inputs are ignored.
  assign is_ready_to_rf = (count < FullCount) && !is_exception_to_rf;
  assign is_full_to_rf  = (count == FullCount);
  assign is_empty_to_rf = (count == '0);

  always_comb begin
    alloc       = is_ready_from_rf && is_ready_to_rf;
    cdb_en      = is_valid_from_cdb && !is_exception_to_rf;
    commit_ok   = valid[head] && done[head] && !is_exception_to_rf;
    commit_jump = commit_ok && jump[head];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid              <= '0;
      done               <= '0;
      jump               <= '0;
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      is_commit_to_rf    <= 1'b0;
      is_exception_to_rf <= 1'b0;
      rd_to_rf           <= '0;
      data_to_rf         <= '0;
      pc_to_rf           <= '0;
      target_to_fetch    <= '0;
    end else begin
      is_commit_to_rf    <= commit_ok && !jump[head];
      is_exception_to_rf <= commit_jump;

      if (commit_ok) begin
        rd_to_rf   <= rd_q[head];
        data_to_rf <= (rd_q[head] == 5'd0) ? '0 : data_q[head];
        pc_to_rf   <= pc_q[head];
        if (jump[head]) target_to_fetch <= target_q[head];
      end

      if (commit_jump) begin
        // Flush overrides allocation, result capture and the count update.
        valid <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        // Matching uses registered valid, so a slot allocated this edge
        // cannot capture a same-cycle broadcast.
        for (int unsigned i = 0; i < Depth; i++) begin
          if (cdb_en && valid[i] && !done[i] && pc_q[i] == pc_from_cdb) begin
            done[i]     <= 1'b1;
            jump[i]     <= is_jump_from_cdb;
            data_q[i]   <= data_from_cdb;
            target_q[i] <= target_from_cdb;
          end
        end

        if (alloc) begin
          valid[tail] <= 1'b1;
          done[tail]  <= 1'b0;
          jump[tail]  <= 1'b0;
          pc_q[tail]  <= pc_from_rf;
          rd_q[tail]  <= rd_from_rf;
          tail        <= tail + 1'b1;
        end

        if (commit_ok) begin
          valid[head] <= 1'b0;
          head        <= head + 1'b1;
        end

        unique case ({alloc, commit_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order commit buffer between the register file's issue stage and the common data bus (CDB). It allocates one entry per instruction issued by the register file, tagged by the instruction PC. It captures execution results broadcast on the CDB and retires entries strictly in program order. It is the writer side of the register file's commit/exception port, driving the `rd`/`data`/`pc` commit pulses and the flush pulse on branch mispredict.

## Interface
- `Depth`, 16: number of entries; power of two.
- `DepthLog2`, 4: log2(`Depth`); head/tail pointer width.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset (`rst==0` at a rising `clk` edge resets).
- `is_ready_from_rf` in 1: issue pulse; allocate an entry this cycle.
- `pc_from_rf` in 32: PC of the issued instruction; this is the entry tag.
- `rd_from_rf` in 5: destination register of the issued instruction.
- `is_valid_from_cdb` in 1: a result broadcast is present.
- `pc_from_cdb` in 32: tag of the result.
- `data_from_cdb` in 32: result value.
- `is_jump_from_cdb` in 1: the instruction was a mispredicted control transfer.
- `target_from_cdb` in 32: correct next PC when `is_jump_from_cdb=1`.
- `is_ready_to_rf` out 1: an entry is free (`count<Depth`); combinational from `count` and the flush flag.
- `is_commit_to_rf` out 1: one-cycle pulse retiring a normal entry.
- `is_exception_to_rf` out 1: one-cycle pulse retiring a mispredict entry; flushes the register file.
- `rd_to_rf` out 5: destination register of the retiring entry.
- `data_to_rf` out 32: value to write for the retiring entry.
- `pc_to_rf` out 32: tag of the retiring entry.
- `target_to_fetch` out 32: redirect PC; meaningful only while `is_exception_to_rf=1`.
- `is_full_to_rf` out 1: `count==Depth`.
- `is_empty_to_rf` out 1: `count==0`.

## Operation
- Per-entry state: `valid`, `done`, `jump`, `pc[31:0]`, `rd[4:0]`, `data[31:0]`, `target[31:0]`.
- Pointers and count:
  - `head` and `tail` are `DepthLog2` bits and wrap modulo `Depth`.
  - `count` is `DepthLog2+1` bits.
- Allocate: when `is_ready_from_rf=1` and `is_ready_to_rf=1`:
  - write `pc`, `rd` at `tail`; set `valid=1`, `done=0`, `jump=0`.
  - increment `tail`.
  - If `is_ready_to_rf=0`, the request is ignored with no state change.
- Result capture: when `is_valid_from_cdb=1`, every entry with `valid=1 && done=0 && pc==pc_from_cdb` latches `data`, `jump`, `target` and sets `done=1`.
  - A CDB tag matching no entry is ignored.
  - An entry being allocated in the same cycle does not match. A result is accepted only from the cycle after allocation.
- Commit: when the head entry has `valid=1 && done=1` (the `done` register state, not same-cycle CDB), exactly one entry retires per cycle.
  - `jump=0`: pulse `is_commit_to_rf`; drive `rd_to_rf`, `data_to_rf`, `pc_to_rf`; clear `valid`; increment `head`.
  - `jump=1`: pulse `is_exception_to_rf` (`is_commit_to_rf` stays 0); drive rd/data/pc and `target_to_fetch`.
    - In the same edge, flush: all `valid=0`, `head=tail=0`, `count=0`.
- x0 guard: when the retiring `rd==0`, `data_to_rf` is forced to 0, so register x0 is never written nonzero.
- Count update:
  - allocate only: `+1`.
  - commit only: `-1`.
  - allocate and commit together: unchanged.
  - flush overrides both and sets `count` to 0.

## Timing
- Reset values, applied while `rst=0` at a clock edge:
  - all `valid=0`; `head=tail=count=0`.
  - `is_commit_to_rf=0`, `is_exception_to_rf=0`.
  - `rd_to_rf=0`, `data_to_rf=0`, `pc_to_rf=0`, `target_to_fetch=0`.
  - `is_ready_to_rf=1`, `is_empty_to_rf=1`, `is_full_to_rf=0`.
- Reset mid-operation discards all entries; no commit pulse follows.
- Commit outputs are registered. A commit decided at edge N is visible during cycle N+1 and is high for exactly one cycle per entry. Outputs hold their last value when idle; only the pulse flags drop to 0.
- Latency:
  - allocate at edge N.
  - CDB result accepted at edge N+1 or later (edge M).
  - commit pulse visible after edge M+1 at the earliest.
- Back-to-back: if consecutive head entries are done, commits pulse on consecutive cycles.
- Full boundary: with `count==Depth`, `is_ready_to_rf=0`. An allocation in a cycle that also commits is still refused; there is no same-cycle slot reuse.
- Flush cycle:
  - During the edge that latches the exception, allocation and CDB inputs are ignored.
  - During the following cycle, while `is_exception_to_rf=1`, `is_ready_to_rf=0` and inputs are ignored.
  - Normal operation resumes on the next cycle.
- Wrap-around: pointers roll from `Depth-1` to 0 with no bubble.

## Test plan
- Reset then single op:
  - stimulus: issue pc=0x04, rd=5; next cycle CDB pc=0x04, data=0x1234.
  - response: one `is_commit_to_rf` pulse with rd=5, data=0x1234, pc=0x04, two cycles after the CDB result.
- Out-of-order completion:
  - stimulus: issue pc 0x00, 0x04, 0x08; CDB returns 0x08, then 0x00, then 0x04.
  - response: commits in order 0x00, 0x04, 0x08; no commit before 0x00's result arrives.
- Full/wrap:
  - stimulus: issue 16 entries; attempt a 17th issue.
  - response: `is_full_to_rf=1`, `is_ready_to_rf=0`, 17th ignored.
  - follow-up: complete all 16 and issue 20 more.
  - response: pointers wrap and every entry commits in order.
- Mispredict:
  - stimulus: entries 0x10, 0x14, 0x18; CDB 0x10 with jump=1, target=0x40, data=0x14, rd=1; 0x14 also done.
  - response: `is_exception_to_rf` pulse with rd=1, data=0x14, `target_to_fetch=0x40`; no commit for 0x14; then empty and ready.
- x0 guard:
  - stimulus: issue rd=0, CDB data=0xFFFF.
  - response: commit with `rd_to_rf=0`, `data_to_rf=0`.
- Unknown tag / reset mid-run:
  - stimulus: CDB pc=0x999 with no matching entry.
  - response: no state change.
  - stimulus: assert `rst=0` with 3 entries pending.
  - response: empty, no commit pulses afterwards.
